// File: rtl/fifo_rptr_empty_ctrl.sv
// Read-side pointer/empty controller for a gray-pointer FIFO (2-flop wptr sync, rbin/rgray, empty, occupancy).
// Optional build macro FIFO_ALMOST_EMPTY_EN adds AE_THRESH and a registered ralmost_empty output.
module fifo_rptr_empty_ctrl #(
  parameter int ADDRSIZE  = 4
`ifdef FIFO_ALMOST_EMPTY_EN
  ,
  parameter int AE_THRESH = 2
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRSIZE:0]   wptr_gray_in,
  input  logic                rinc,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic                rempty,
  output logic [ADDRSIZE:0]   rcount,
  output logic                ptr_err
`ifdef FIFO_ALMOST_EMPTY_EN
  ,
  output logic                ralmost_empty
`endif
);

  localparam logic [ADDRSIZE:0] LP_DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

  logic [ADDRSIZE:0] r_wq1;
  logic [ADDRSIZE:0] r_wq2;
  logic [ADDRSIZE:0] r_rbin;
  logic [ADDRSIZE:0] r_rgray;
  logic              r_empty;
  logic              r_err;

  logic [ADDRSIZE:0] w_wbin;
  logic [ADDRSIZE:0] w_rbin_next;
  logic [ADDRSIZE:0] w_rgray_next;
  logic [ADDRSIZE:0] w_rcount;
  logic              w_ren;

  // Gray-to-binary as a running XOR from the MSB down, constant indices only.
  always_comb begin
    w_wbin = '0;
    w_wbin[ADDRSIZE] = r_wq2[ADDRSIZE];
    for (int unsigned k = 0; k < ADDRSIZE; k++) begin
      w_wbin[ADDRSIZE-1-k] = w_wbin[ADDRSIZE-k] ^ r_wq2[ADDRSIZE-1-k];
    end
  end

  assign w_ren        = rinc & ~r_empty;
  assign w_rbin_next  = r_rbin + (ADDRSIZE+1)'(w_ren);
  assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
  assign w_rcount     = w_wbin - r_rbin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wq1   <= '0;
      r_wq2   <= '0;
      r_rbin  <= '0;
      r_rgray <= '0;
      r_empty <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_wq1   <= wptr_gray_in;
      r_wq2   <= r_wq1;
      r_rbin  <= w_rbin_next;
      r_rgray <= w_rgray_next;
      r_empty <= (w_rgray_next == r_wq2);
      r_err   <= r_err | (w_rcount > LP_DEPTH);
    end
  end

  assign raddr     = r_rbin[ADDRSIZE-1:0];
  assign rptr_gray = r_rgray;
  assign rempty    = r_empty;
  assign rcount    = w_rcount;
  assign ptr_err   = r_err;

`ifdef FIFO_ALMOST_EMPTY_EN
  logic [ADDRSIZE:0] w_ae_occ;
  logic              r_ae;

  assign w_ae_occ = w_wbin - w_rbin_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ae <= 1'b1;
    end else begin
      r_ae <= (w_ae_occ <= (ADDRSIZE+1)'(AE_THRESH));
    end
  end

  assign ralmost_empty = r_ae;
`endif

endmodule

// File: tb/tb_fifo_rptr_empty_ctrl.sv
// Bench for fifo_rptr_empty_ctrl: directed scenarios plus random traffic against an occupancy-based model.
module tb_fifo_rptr_empty_ctrl;
  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int PMASK = (1 << PW) - 1;
  localparam int DEPTH = 1 << AW;
`ifdef FIFO_ALMOST_EMPTY_EN
  localparam int AE    = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rinc = 1'b0;
  logic [AW:0]   wptr_gray_in = '0;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr_gray;
  logic          rempty;
  logic [AW:0]   rcount;
  logic          ptr_err;
`ifdef FIFO_ALMOST_EMPTY_EN
  logic          ralmost_empty;
`endif

  fifo_rptr_empty_ctrl #(
    .ADDRSIZE (AW)
`ifdef FIFO_ALMOST_EMPTY_EN
    ,
    .AE_THRESH(AE)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wptr_gray_in (wptr_gray_in),
    .rinc         (rinc),
    .raddr        (raddr),
    .rptr_gray    (rptr_gray),
    .rempty       (rempty),
    .rcount       (rcount),
    .ptr_err      (ptr_err)
`ifdef FIFO_ALMOST_EMPTY_EN
    ,
    .ralmost_empty(ralmost_empty)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: synchronizer stages as gray values, read count, and flags derived from occupancy.
  int m_wq1, m_wq2, m_rd, m_wcnt;
  bit m_empty, m_err;
`ifdef FIFO_ALMOST_EMPTY_EN
  bit m_ae;
`endif

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & PMASK;
  endfunction

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < PW; s++) b = b ^ (g >> s);
    return b & PMASK;
  endfunction

  function automatic int occ_of(input int wg, input int rd);
    return (g2b(wg) - rd) & PMASK;
  endfunction

  task automatic step(input bit r, input bit ri, input int wg);
    int occ_n;
    bit ren;
    rst = r;
    rinc = ri;
    wptr_gray_in = PW'(wg);
    @(posedge clk);
    if (r) begin
      m_wq1 = 0; m_wq2 = 0; m_rd = 0; m_empty = 1'b1; m_err = 1'b0;
`ifdef FIFO_ALMOST_EMPTY_EN
      m_ae = 1'b1;
`endif
    end else begin
      ren = ri && !m_empty;
      if (occ_of(m_wq2, m_rd) > DEPTH) m_err = 1'b1;
      m_rd = (m_rd + (ren ? 1 : 0)) & PMASK;
      occ_n = occ_of(m_wq2, m_rd);
      m_empty = (occ_n == 0);
`ifdef FIFO_ALMOST_EMPTY_EN
      m_ae = (occ_n <= AE);
`endif
      m_wq2 = m_wq1;
      m_wq1 = wg & PMASK;
    end
    #1;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 3);
    step(1'b1, 1'b0, 3);
    m_wcnt = 0;
    n_checks++; if (rempty !== 1'b1) begin n_errors++; $display("FAIL reset_rempty got=%0b exp=1", rempty); end
    n_checks++; if (rcount !== '0) begin n_errors++; $display("FAIL reset_rcount got=%0d exp=0", rcount); end
    n_checks++; if (raddr !== '0) begin n_errors++; $display("FAIL reset_raddr got=%0d exp=0", raddr); end
    n_checks++; if (ptr_err !== 1'b0) begin n_errors++; $display("FAIL reset_ptr_err got=%0b exp=0", ptr_err); end
    n_checks++; if (rptr_gray !== '0) begin n_errors++; $display("FAIL reset_rptr_gray got=%b exp=00000", rptr_gray); end
  endtask

  task automatic test_fill;
    for (int k = 0; k < 7; k++) begin
      m_wcnt = (k < 2) ? k + 1 : 3;
      step(1'b0, 1'b0, gray(m_wcnt));
      n_checks++; if (rempty !== (k < 2)) begin n_errors++; $display("FAIL fill_rempty edge=%0d got=%0b exp=%0b", k + 1, rempty, k < 2); end
      n_checks++; if (rcount !== PW'(occ_of(m_wq2, m_rd))) begin n_errors++; $display("FAIL fill_rcount edge=%0d got=%0d exp=%0d", k + 1, rcount, occ_of(m_wq2, m_rd)); end
    end
    n_checks++; if (rcount !== PW'(3)) begin n_errors++; $display("FAIL fill_final_rcount got=%0d exp=3", rcount); end
  endtask

  task automatic test_drain;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, gray(m_wcnt));
      n_checks++; if (raddr !== AW'((k < 3) ? k + 1 : 3)) begin n_errors++; $display("FAIL drain_raddr k=%0d got=%0d exp=%0d", k, raddr, (k < 3) ? k + 1 : 3); end
      n_checks++; if (rempty !== (k >= 2)) begin n_errors++; $display("FAIL drain_rempty k=%0d got=%0b exp=%0b", k, rempty, k >= 2); end
      n_checks++; if (rcount !== PW'(occ_of(m_wq2, m_rd))) begin n_errors++; $display("FAIL drain_rcount k=%0d got=%0d exp=%0d", k, rcount, occ_of(m_wq2, m_rd)); end
    end
    n_checks++; if (ptr_err !== 1'b0) begin n_errors++; $display("FAIL drain_ptr_err got=%0b exp=0", ptr_err); end
  endtask

  task automatic test_wrap;
    int guard;
    bit wr;
    bit seen16;
    step(1'b1, 1'b0, 0);
    m_wcnt = 0;
    guard = 0;
    while (m_rd != 15 && guard < 400) begin
      wr = (m_wcnt < 15) && bit'($urandom_range(0, 1)) && (((m_wcnt - m_rd) & PMASK) < DEPTH);
      if (wr) m_wcnt++;
      step(1'b0, bit'($urandom_range(0, 1)), gray(m_wcnt));
      guard++;
      n_checks++; if (raddr !== AW'(m_rd) || rptr_gray !== PW'(gray(m_rd)) || rempty !== m_empty)
        begin n_errors++; $display("FAIL wrap_pre raddr=%0d gray=%b empty=%0b exp raddr=%0d gray=%b empty=%0b", raddr, rptr_gray, rempty, AW'(m_rd), PW'(gray(m_rd)), m_empty); end
    end
    n_checks++; if (guard >= 400) begin n_errors++; $display("FAIL wrap_timeout got=rd%0d exp=rd15", m_rd); end
    n_checks++; if (rptr_gray !== 5'b01000) begin n_errors++; $display("FAIL wrap_gray15 got=%b exp=01000", rptr_gray); end
    guard = 0;
    seen16 = 1'b0;
    while (m_rd != 17 && guard < 20) begin
      m_wcnt = (guard == 0) ? 16 : 17;
      step(1'b0, 1'b1, gray(m_wcnt));
      guard++;
      if (m_rd == 16 && !seen16) begin
        seen16 = 1'b1;
        n_checks++; if (rptr_gray !== 5'b11000) begin n_errors++; $display("FAIL wrap_gray16 got=%b exp=11000", rptr_gray); end
      end
    end
    n_checks++; if (guard >= 20) begin n_errors++; $display("FAIL wrap_timeout2 got=rd%0d exp=rd17", m_rd); end
    n_checks++; if (rptr_gray !== 5'b11001) begin n_errors++; $display("FAIL wrap_gray17 got=%b exp=11001", rptr_gray); end
    n_checks++; if (rempty !== 1'b1) begin n_errors++; $display("FAIL wrap_rempty got=%0b exp=1", rempty); end
  endtask

  task automatic test_error;
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 5'b11110);
    n_checks++; if (rcount !== PW'(20)) begin n_errors++; $display("FAIL err_rcount got=%0d exp=20", rcount); end
    n_checks++; if (ptr_err !== 1'b1) begin n_errors++; $display("FAIL err_set got=%0b exp=1", ptr_err); end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, bit'($urandom_range(0, 1)), 5'b11110);
      n_checks++; if (ptr_err !== 1'b1) begin n_errors++; $display("FAIL err_sticky k=%0d got=%0b exp=1", k, ptr_err); end
      n_checks++; if (rcount !== PW'(occ_of(m_wq2, m_rd)) || raddr !== AW'(m_rd))
        begin n_errors++; $display("FAIL err_traffic rcount=%0d raddr=%0d exp %0d %0d", rcount, raddr, occ_of(m_wq2, m_rd), AW'(m_rd)); end
    end
    step(1'b1, 1'b0, 0);
    m_wcnt = 0;
    n_checks++; if (ptr_err !== 1'b0) begin n_errors++; $display("FAIL err_clear got=%0b exp=0", ptr_err); end
  endtask

  task automatic test_random;
    bit wr;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        m_wcnt = 0;
        step(1'b1, bit'($urandom_range(0, 1)), gray(5));
      end else begin
        wr = bit'($urandom_range(0, 1)) && (((m_wcnt - m_rd) & PMASK) < DEPTH);
        if (wr) m_wcnt = (m_wcnt + 1) & PMASK;
        step(1'b0, bit'($urandom_range(0, 1)), gray(m_wcnt));
      end
      n_checks++; if (raddr !== AW'(m_rd)) begin n_errors++; $display("FAIL rnd_raddr c=%0d got=%0d exp=%0d", c, raddr, AW'(m_rd)); end
      n_checks++; if (rptr_gray !== PW'(gray(m_rd))) begin n_errors++; $display("FAIL rnd_rptr_gray c=%0d got=%b exp=%b", c, rptr_gray, PW'(gray(m_rd))); end
      n_checks++; if (rempty !== m_empty) begin n_errors++; $display("FAIL rnd_rempty c=%0d got=%0b exp=%0b", c, rempty, m_empty); end
      n_checks++; if (rcount !== PW'(occ_of(m_wq2, m_rd))) begin n_errors++; $display("FAIL rnd_rcount c=%0d got=%0d exp=%0d", c, rcount, occ_of(m_wq2, m_rd)); end
      n_checks++; if (ptr_err !== m_err) begin n_errors++; $display("FAIL rnd_ptr_err c=%0d got=%0b exp=%0b", c, ptr_err, m_err); end
`ifdef FIFO_ALMOST_EMPTY_EN
      n_checks++; if (ralmost_empty !== m_ae) begin n_errors++; $display("FAIL rnd_ae c=%0d got=%0b exp=%0b", c, ralmost_empty, m_ae); end
`endif
    end
  endtask

`ifdef FIFO_ALMOST_EMPTY_EN
  task automatic test_almost_empty;
    step(1'b1, 1'b0, 0);
    m_wcnt = 4;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, gray(4));
    n_checks++; if (ralmost_empty !== 1'b0) begin n_errors++; $display("FAIL ae_occ4 got=%0b exp=0", ralmost_empty); end
    step(1'b0, 1'b1, gray(4));
    n_checks++; if (ralmost_empty !== 1'b0) begin n_errors++; $display("FAIL ae_occ3 got=%0b exp=0", ralmost_empty); end
    step(1'b0, 1'b1, gray(4));
    n_checks++; if (ralmost_empty !== 1'b1) begin n_errors++; $display("FAIL ae_occ2 got=%0b exp=1", ralmost_empty); end
    step(1'b0, 1'b1, gray(4));
    step(1'b0, 1'b1, gray(4));
    n_checks++; if (ralmost_empty !== 1'b1 || rempty !== 1'b1) begin n_errors++; $display("FAIL ae_empty got ae=%0b empty=%0b exp=1 1", ralmost_empty, rempty); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_error();
`ifdef FIFO_ALMOST_EMPTY_EN
    test_almost_empty();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
